// File: rtl/addergen_pkg.sv
// rtl/addergen_pkg.sv - shared chunk sizing helper and stage record template for addergen_pipe
package addergen_pkg;

  localparam int TMPL_WIDTH  = 32;
  localparam int TMPL_STAGES = 4;

  function automatic int chunk_w(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  localparam int TMPL_CHUNK = chunk_w(TMPL_WIDTH, TMPL_STAGES);

  // Upper operand chunks are kept right-aligned so each stage always adds bits [CHUNK-1:0].
  typedef struct packed {
    logic                  valid;
    logic                  carry;
    logic [TMPL_WIDTH-1:0] sum;
    logic [TMPL_WIDTH-1:0] a_hi;
    logic [TMPL_WIDTH-1:0] b_hi;
`ifdef ADDERGEN_PIPE_SUB_EN
    logic                  sub;
`endif
  } stage_t;

endpackage

// File: rtl/addergen_chunk.sv
// rtl/addergen_chunk.sv - combinational CHUNK-bit ripple adder built from per-bit full adders
module addergen_chunk
  import addergen_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/addergen_pipe.sv
// rtl/addergen_pipe.sv - elastic pipelined chunked adder; ADDERGEN_PIPE_SUB_EN adds sub/ovf
module addergen_pipe
  import addergen_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef ADDERGEN_PIPE_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("addergen_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  // Index s is the input side of stage s; index STAGES is the output register.
  logic             st_valid [STAGES+1];
  logic             st_carry [STAGES+1];
  logic [WIDTH-1:0] st_sum   [STAGES+1];
  logic [WIDTH-1:0] op_a     [STAGES];
  logic [WIDTH-1:0] op_b     [STAGES];
  logic [STAGES:0]  ready;

  logic [WIDTH-1:0] b_eff;
  logic             cin0;

`ifdef ADDERGEN_PIPE_SUB_EN
  logic ovf_q;

  assign b_eff = sub ? ~b : b;
  assign cin0  = sub ? 1'b1 : ci;
  assign ovf   = ovf_q;
`else
  assign b_eff = b;
  assign cin0  = ci;
`endif

  assign st_valid[0]   = in_valid;
  assign st_carry[0]   = cin0;
  assign st_sum[0]     = '0;
  assign op_a[0]       = a;
  assign op_b[0]       = b_eff;
  assign ready[STAGES] = out_ready;
  assign in_ready      = rst_n & ready[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_co;
    logic [WIDTH-1:0] sum_d;
    logic             valid_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;

    addergen_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a  (op_a[s][CHUNK-1:0]),
      .b  (op_b[s][CHUNK-1:0]),
      .ci (st_carry[s]),
      .s  (chunk_sum),
      .co (chunk_co)
    );

    always_comb begin
      sum_d                      = st_sum[s];
      sum_d[s*CHUNK +: CHUNK]    = chunk_sum;
    end

    // Bubbles load zeros so data outputs never show stale operands while invalid.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (ready[s]) begin
        valid_q <= st_valid[s];
        carry_q <= st_valid[s] & chunk_co;
        sum_q   <= st_valid[s] ? sum_d : '0;
      end
    end

    assign st_valid[s+1] = valid_q;
    assign st_carry[s+1] = carry_q;
    assign st_sum[s+1]   = sum_q;
    assign ready[s]      = !valid_q || ready[s+1];

    if (s < STAGES - 1) begin : g_ops
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ready[s]) begin
          a_q <= st_valid[s] ? (op_a[s] >> CHUNK) : '0;
          b_q <= st_valid[s] ? (op_b[s] >> CHUNK) : '0;
        end
      end

      assign op_a[s+1] = a_q;
      assign op_b[s+1] = b_q;
    end

`ifdef ADDERGEN_PIPE_SUB_EN
    // The top chunk carries the operand sign bits, so overflow is resolved in the last stage.
    if (s == STAGES - 1) begin : g_ovf
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (ready[s]) begin
          ovf_q <= st_valid[s]
                   && (op_a[s][CHUNK-1] == op_b[s][CHUNK-1])
                   && (chunk_sum[CHUNK-1] != op_a[s][CHUNK-1]);
        end
      end
    end
`endif
  end

  assign out_valid = st_valid[STAGES];
  assign sum       = st_sum[STAGES];
  assign co        = st_carry[STAGES];

endmodule

// File: tb/tb_addergen_pipe.sv
// tb/tb_addergen_pipe.sv - directed self-checking bench for addergen_pipe
module tb_addergen_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         ci = 1'b0;
  logic         out_ready = 1'b1;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, co;
  logic [W-1:0] sum;
  logic         ovf;

  logic         in_valid_w = 1'b0;
  logic         ci_w = 1'b0;
  logic         rdy_w = 1'b1;
  logic [31:0]  a_w = '0;
  logic [31:0]  b_w = '0;
  logic         ir4, ir1, ov4, ov1, co4, co1;
  logic [31:0]  sum4, sum1;
  logic         ovf4, ovf1;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_out = 0;
  logic last_acc = 1'b0;
  logic [8:0]  exp_q [$];
  logic [32:0] q4 [$];
  logic [32:0] q1 [$];

  always #5 clk = ~clk;

  addergen_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci),
`ifdef ADDERGEN_PIPE_SUB_EN
    .sub(sub), .ovf(ovf),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .co(co)
  );

  addergen_pipe #(.WIDTH(32), .STAGES(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(ir4),
    .a(a_w), .b(b_w), .ci(ci_w),
`ifdef ADDERGEN_PIPE_SUB_EN
    .sub(1'b0), .ovf(ovf4),
`endif
    .out_valid(ov4), .out_ready(rdy_w), .sum(sum4), .co(co4)
  );

  addergen_pipe #(.WIDTH(32), .STAGES(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(ir1),
    .a(a_w), .b(b_w), .ci(ci_w),
`ifdef ADDERGEN_PIPE_SUB_EN
    .sub(1'b0), .ovf(ovf1),
`endif
    .out_valid(ov1), .out_ready(rdy_w), .sum(sum1), .co(co1)
  );

`ifndef ADDERGEN_PIPE_SUB_EN
  assign ovf  = 1'b0;
  assign ovf4 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y,
                                        input logic c, input logic s);
    logic [7:0] yy;
    yy = s ? ~y : y;
    return {1'b0, x} + {1'b0, yy} + 9'(s ? 1'b1 : c);
  endfunction

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_new();
    a  = 8'($urandom);
    b  = 8'($urandom);
    ci = 1'($urandom);
  endtask

  task automatic cycle();
    logic del;
    #2;
    last_acc = in_valid && in_ready;
    del      = out_valid && out_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", 33'(out_valid), 33'd0);
      else                   check("result", 33'({co, sum}), 33'(exp_q[0]));
    end else begin
      check("idle_zero", 33'({co, sum}), 33'd0);
    end
    if (del && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      n_out++;
    end
    if (last_acc) begin
      exp_q.push_back(model8(a, b, ci, sub));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_w();
    #2;
    if (ov4) begin
      if (q4.size() == 0) check("w4_spurious", 33'(ov4), 33'd0);
      else                check("w4_result", {co4, sum4}, q4.pop_front());
    end
    if (ov1) begin
      if (q1.size() == 0) check("w1_spurious", 33'(ov1), 33'd0);
      else                check("w1_result", {co1, sum1}, q1.pop_front());
    end
    if (in_valid_w && ir4) q4.push_back({1'b0, a_w} + {1'b0, b_w} + 33'(ci_w));
    if (in_valid_w && ir1) q1.push_back({1'b0, a_w} + {1'b0, b_w} + 33'(ci_w));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle();
    check(tag, 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    // Reset with live random stimulus.
    for (int i = 0; i < 3; i++) begin
      drive_new();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    #2;
    check("rst_out_valid", 33'(out_valid), 33'd0);
    check("rst_sum", 33'(sum), 33'd0);
    check("rst_co", 33'(co), 33'd0);
    check("rst_in_ready", 33'(in_ready), 33'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    check("release_in_ready", 33'(in_ready), 33'd1);
    check("release_out_valid", 33'(out_valid), 33'd0);

    // Single op, latency 2.
    a = 8'hF0; b = 8'h1F; ci = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    #2;
    check("single_lat1_valid", 33'(out_valid), 33'd0);
    cycle();
    #2;
    check("single_valid", 33'(out_valid), 33'd1);
    check("single_sum", 33'(sum), 33'h10);
    check("single_co", 33'(co), 33'd1);
    cycle();

    // 100 back-to-back ops.
    n_out = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_new();
      cycle();
      check("stream_in_ready", 33'(last_acc), 33'd1);
    end
    drain("stream_drain");
    check("stream_count", 33'(n_out), 33'd100);

    // Backpressure: two accepts fill the pipe, output held stable.
    n_acc = 0;
    n_out = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_new();
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (last_acc) drive_new();
    end
    #2;
    check("bp_accepts", 33'(n_acc), 33'd2);
    check("bp_in_ready", 33'(in_ready), 33'd0);
    drain("bp_drain");
    check("bp_count", 33'(n_out), 33'd2);

    // Random stalls with overlapping input and output transfers.
    for (int i = 0; i < 60; i++) begin
      if (last_acc || !in_valid) drive_new();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom);
      cycle();
    end
    drain("stall_drain");

    // Mid-operation reset discards both in-flight ops.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_new();
    cycle();
    drive_new();
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    exp_q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("midrst_no_valid", 33'(out_valid), 33'd0);
    end
    a = 8'h01; b = 8'hFF; ci = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    #2;
    check("midrst_lat1", 33'(out_valid), 33'd0);
    cycle();
    #2;
    check("midrst_valid", 33'(out_valid), 33'd1);
    check("midrst_sum", 33'({co, sum}), 33'h100);
    cycle();

`ifdef ADDERGEN_PIPE_SUB_EN
    sub = 1'b1; a = 8'h80; b = 8'h01; ci = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    #2;
    check("sub_valid", 33'(out_valid), 33'd1);
    check("sub_sum", 33'(sum), 33'h7F);
    check("sub_co", 33'(co), 33'd1);
    check("sub_ovf", 33'(ovf), 33'd1);
    cycle();
    sub = 1'b0;
`endif

    // 32-bit builds, four stages and one stage.
    in_valid_w = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_w  = $urandom;
      b_w  = $urandom;
      ci_w = 1'($urandom);
      if (i == 0) begin
        a_w = 32'hFFFF_FFFF; b_w = 32'h0000_0000; ci_w = 1'b1;
      end
      cycle_w();
    end
    in_valid_w = 1'b0;
    for (int i = 0; i < 8; i++) cycle_w();
    check("w4_drain", 33'(q4.size()), 33'd0);
    check("w1_drain", 33'(q1.size()), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
